usb_ls_tx: RTL and testbench

USB_LS_TX -- requirements
Module: usb_ls_tx

---
 rtl/usb_ls_pkg.sv | 20 ++
 rtl/usb_ls_bitenc.sv | 44 ++++
 rtl/usb_ls_tx.sv | 187 ++++++++++++++++++
 tb/tb_usb_ls_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/usb_ls_pkg.sv
// Shared types and constants for the low-speed USB transmitter.
package usb_ls_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StEopSe0,
    StEopJ
  } usb_ls_state_e;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  // Line states packed as {dp, dm}.
  localparam logic [1:0] LINE_J   = 2'b01;
  localparam logic [1:0] LINE_K   = 2'b10;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_ls_bitenc.sv
// NRZI encoder with bit-stuff tracking. line_k reflects the bit presented this cycle
// when bit_strobe is high, so the caller can register it on the same edge.
module usb_ls_bitenc
  import usb_ls_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_strobe,
  input  logic restart,
  output logic line_k,
  output logic stuff_req
);

  logic       k_q;
  logic       k_base;
  logic [2:0] ones_q;
  logic [2:0] ones_base;
  logic [2:0] ones_d;

  // restart rewinds to J with no ones seen, and may coincide with the first strobe.
  assign k_base    = restart ? 1'b0 : k_q;
  assign ones_base = restart ? 3'd0 : ones_q;
  assign line_k    = (bit_strobe && !bit_in) ? ~k_base : k_base;
  assign stuff_req = (ones_q == STUFF_LIMIT);

  always_comb begin
    ones_d = ones_base;
    if (bit_strobe) begin
      ones_d = bit_in ? ones_base + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q    <= 1'b0;
      ones_q <= 3'd0;
    end else begin
      k_q    <= line_k;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/usb_ls_tx.sv
// Low-speed USB packet transmitter: one-byte buffer, SYNC, NRZI data with bit stuffing
// and EOP generation on registered D+/D- drive outputs.
module usb_ls_tx
  import usb_ls_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       underrun,
  output logic       dp_o,
  output logic       dm_o,
  output logic       oe
);

  localparam int unsigned CntW = $clog2(2 * CLK_DIV);
  localparam logic [CntW-1:0] BitLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] Se0Last = CntW'(2 * CLK_DIV - 1);

  usb_ls_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      cur_q, cur_d;
  logic            cur_last_q, cur_last_d;
  logic [7:0]      buf_data_q, buf_data_d;
  logic            buf_last_q, buf_last_d;
  logic            buf_full_q, buf_full_d;
  logic [1:0]      line_q, line_d;
  logic            oe_q;
  logic            underrun_q, underrun_d;

  logic       accept;
  logic       bit_end;
  logic       load;
  logic [2:0] next_idx;
  logic [7:0] next_byte;
  logic       next_last;
  logic       enc_bit;
  logic       enc_strobe;
  logic       enc_restart;
  logic       line_k;
  logic       stuff_req;

  assign tx_ready  = ~buf_full_q & (state_q != StEopSe0) & (state_q != StEopJ) & ~reset;
  assign accept    = tx_valid & tx_ready;
  assign bit_end   = (cnt_q == BitLast);
  assign next_idx  = bit_idx_q + 3'd1;
  // A byte accepted on the boundary edge itself goes straight to the shifter.
  assign next_byte = buf_full_q ? buf_data_q : tx_data;
  assign next_last = buf_full_q ? buf_last_q : tx_last;

  usb_ls_bitenc u_bitenc (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (enc_bit),
    .bit_strobe (enc_strobe),
    .restart    (enc_restart),
    .line_k     (line_k),
    .stuff_req  (stuff_req)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    bit_idx_d   = bit_idx_q;
    cur_d       = cur_q;
    cur_last_d  = cur_last_q;
    underrun_d  = 1'b0;
    load        = 1'b0;
    enc_bit     = 1'b0;
    enc_strobe  = 1'b0;
    enc_restart = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (buf_full_q || accept) begin
          state_d     = StSync;
          bit_idx_d   = 3'd0;
          enc_restart = 1'b1;
          enc_strobe  = 1'b1;
          enc_bit     = SYNC_BYTE[0];
        end
      end
      StSync, StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stuff_req) begin
            enc_strobe = 1'b1;
            enc_bit    = 1'b0;
          end else if (bit_idx_q != 3'd7) begin
            bit_idx_d  = next_idx;
            enc_strobe = 1'b1;
            enc_bit    = (state_q == StSync) ? SYNC_BYTE[next_idx] : cur_q[next_idx];
          end else if (state_q == StData && cur_last_q) begin
            state_d = StEopSe0;
          end else if (buf_full_q || accept) begin
            load       = 1'b1;
            state_d    = StData;
            cur_d      = next_byte;
            cur_last_d = next_last;
            bit_idx_d  = 3'd0;
            enc_strobe = 1'b1;
            enc_bit    = next_byte[0];
          end else begin
            underrun_d = 1'b1;
            state_d    = StEopSe0;
          end
        end
      end
      StEopSe0: begin
        if (cnt_q == Se0Last) begin
          state_d = StEopJ;
          cnt_d   = '0;
        end
      end
      StEopJ: begin
        if (bit_end) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    if (load) begin
      buf_full_d = 1'b0;
    end else if (accept) begin
      buf_full_d = 1'b1;
      buf_data_d = tx_data;
      buf_last_d = tx_last;
    end
  end

  always_comb begin
    case (state_d)
      StSync, StData: line_d = line_k ? LINE_K : LINE_J;
      StEopSe0:       line_d = LINE_SE0;
      default:        line_d = LINE_J;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      cur_q      <= 8'h00;
      cur_last_q <= 1'b0;
      buf_data_q <= 8'h00;
      buf_last_q <= 1'b0;
      buf_full_q <= 1'b0;
      line_q     <= LINE_J;
      oe_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      cur_q      <= cur_d;
      cur_last_q <= cur_last_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      buf_full_q <= buf_full_d;
      line_q     <= line_d;
      oe_q       <= (state_d != StIdle);
      underrun_q <= underrun_d;
    end
  end

  assign tx_busy  = (state_q != StIdle);
  assign underrun = underrun_q;
  assign dp_o     = line_q[1];
  assign dm_o     = line_q[0];
  assign oe       = oe_q;

endmodule

// File: tb/tb_usb_ls_tx.sv
// Scoreboarded bench: each packet's per-clock {underrun, dp, dm} trace is queued at drive
// time and popped by a monitor for every cycle oe is high.
module tb_usb_ls_tx;

  localparam int CLK_DIV = 8;
  localparam logic [1:0] LJ   = 2'b01;
  localparam logic [1:0] LK   = 2'b10;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       underrun;
  logic       dp_o;
  logic       dm_o;
  logic       oe;

  int n_checks;
  int n_fail;
  int oe_cnt;
  logic [2:0] exp_q[$];

  usb_ls_tx #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .underrun (underrun),
    .dp_o     (dp_o),
    .dm_o     (dm_o),
    .oe       (oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 3'b111 is never a legal {underrun, dp, dm}, so an unexpected oe cycle fails.
  always @(negedge clk) begin
    logic [2:0] e;
    if (!reset) begin
      if (oe) begin
        oe_cnt++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b111;
        check("line", {29'd0, underrun, dp_o, dm_o}, {29'd0, e});
      end else begin
        check("idle_line", {29'd0, underrun, dp_o, dm_o}, {29'd0, 1'b0, LJ});
      end
    end
  end

  task automatic push_bit(input logic [1:0] lvl);
    for (int i = 0; i < CLK_DIV; i++) exp_q.push_back({1'b0, lvl});
  endtask

  task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                              input bit ur);
    logic [1:0] lvl;
    logic [7:0] cur;
    int ones;
    lvl  = LJ;
    ones = 0;
    for (int k = 0; k <= nbytes; k++) begin
      cur = (k == 0) ? 8'h80 : ((k == 1) ? b0 : b1);
      for (int b = 0; b < 8; b++) begin
        if (!cur[b]) lvl = (lvl == LJ) ? LK : LJ;
        push_bit(lvl);
        ones = cur[b] ? ones + 1 : 0;
        if (ones == 6) begin
          lvl = (lvl == LJ) ? LK : LJ;
          push_bit(lvl);
          ones = 0;
        end
      end
    end
    exp_q.push_back({ur, LSE0});
    for (int i = 1; i < 2 * CLK_DIV; i++) exp_q.push_back({1'b0, LSE0});
    push_bit(LJ);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] d, input logic last, input bit hold);
    int waited;
    waited   = 0;
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    while (!tx_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_oe);
    int n;
    n = 0;
    while (tx_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_drop"}, {31'd0, tx_busy}, 32'd0);
    check({tag, "_oe_cycles"}, oe_cnt, exp_oe);
    check({tag, "_queue_left"}, exp_q.size(), 32'd0);
  endtask

  task automatic run_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input int nbytes, input bit last_flag, input int exp_oe);
    model_packet(b0, b1, nbytes, !last_flag);
    oe_cnt = 0;
    if (nbytes == 1) begin
      send_byte(b0, last_flag, 1'b0);
    end else begin
      send_byte(b0, 1'b0, 1'b1);
      send_byte(b1, last_flag, 1'b0);
    end
    wait_done(tag, exp_oe);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe"}, {31'd0, oe}, 32'd0);
    check({tag, "_line"}, {30'd0, dp_o, dm_o}, {30'd0, LJ});
    check({tag, "_busy"}, {31'd0, tx_busy}, 32'd0);
    check({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
    check({tag, "_ready"}, {31'd0, tx_ready}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    oe_cnt   = 0;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    #1 check("ready_after_por", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);

    run_packet("c3", 8'hC3, 8'h00, 1, 1'b1, 152);
    run_packet("ff_stuff", 8'hFF, 8'h00, 1, 1'b1, 160);
    run_packet("fc_tail_stuff", 8'hFC, 8'h00, 1, 1'b1, 160);
    run_packet("b2b", 8'h2D, 8'h00, 2, 1'b1, 216);
    run_packet("underrun", 8'hA5, 8'h00, 1, 1'b0, 152);

    // Abandon a packet in DATA, then confirm a clean restart.
    model_packet(8'hC3, 8'h00, 1, 1'b0);
    oe_cnt = 0;
    send_byte(8'hC3, 1'b1, 1'b0);
    repeat (90) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("mid_rst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check("ready_after_mid_rst", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    run_packet("c3_after_rst", 8'hC3, 8'h00, 1, 1'b1, 152);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
